ct_butterfly_stage: RTL and testbench

Modular Cooley-Tukey add/sub stage sitting directly downstream of the Barrett modular multiplier in the NTT datapath. It receives the top operand `u` and the already-reduced product `p = v·w mod q`. It emits `x = (u + p) mod q` and `y = (u − p) mod q` through a 2-stage valid/ready pipeline. A small FSM frames each NTT pass of `BFLY_COUNT` butterflies and signals pass completion.

---
 rtl/ct_butterfly_stage.sv | 179 +++++++++++++++++
 tb/tb_ct_butterfly_stage.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_butterfly_stage.sv
// ============================================================================
//  Module      : ct_butterfly_stage
//  Description : Modular Cooley-Tukey add/sub stage. Takes u and the reduced
//                product p, emits x = (u+p) mod q and y = (u-p) mod q through
//                a 2-stage valid/ready pipeline, and frames each NTT pass of
//                BFLY_COUNT butterflies with a pass_done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef D_width
`define D_width 8
`endif

module ct_butterfly_stage #(
  parameter int DATA_WIDTH = `D_width,
  parameter int BFLY_COUNT = 16,
  parameter int CNT_WIDTH  = (BFLY_COUNT > 1) ? $clog2(BFLY_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active low
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] modulus,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] u,
  input  logic [DATA_WIDTH-1:0] p,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y,
  output logic [CNT_WIDTH-1:0]  bfly_idx,
  output logic                  pass_done
);

  localparam logic [CNT_WIDTH-1:0] c_last_idx = CNT_WIDTH'(BFLY_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_start_ok;

  logic [DATA_WIDTH-1:0] r_q;
  logic [CNT_WIDTH-1:0]  r_in_cnt;
  logic [CNT_WIDTH-1:0]  r_out_cnt;

  logic                  r_s1_valid;
  logic [DATA_WIDTH:0]   r_s1_sum;
  logic [DATA_WIDTH:0]   r_s1_dif;

  logic                  r_s2_valid;
  logic [DATA_WIDTH-1:0] r_x;
  logic [DATA_WIDTH-1:0] r_y;
  logic                  r_pass_done;

  logic                  w_s2_adv;
  logic                  w_s1_adv;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic [DATA_WIDTH-1:0] w_x_nxt;
  logic [DATA_WIDTH-1:0] w_y_nxt;

  // Pipeline advance: a stage may load when it is empty or its content leaves.
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = (r_state == S_RUN) && w_s1_adv;
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = r_s2_valid && out_ready;

  assign out_valid = r_s2_valid;
  assign x         = r_x;
  assign y         = r_y;
  // The output counter only moves on an output handshake, so it names the
  // butterfly sitting in stage 2 and stays stable during a stall.
  assign bfly_idx  = r_out_cnt;
  assign pass_done = r_pass_done;

  // Final conditional correction; truncated arithmetic gives the right low bits.
  assign w_x_nxt = (r_s1_sum >= {1'b0, r_q}) ? (r_s1_sum[DATA_WIDTH-1:0] - r_q)
                                             : r_s1_sum[DATA_WIDTH-1:0];
  assign w_y_nxt = r_s1_dif[DATA_WIDTH] ? (r_s1_dif[DATA_WIDTH-1:0] + r_q)
                                        : r_s1_dif[DATA_WIDTH-1:0];

  // Pass-framing FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_in_hs && (r_in_cnt == c_last_idx)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_hs && (r_out_cnt == c_last_idx)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; pass_done is registered so it is high exactly in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pass_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pass_done <= (w_state_nxt == S_DONE);
    end
  end

  // Modulus latch and butterfly counters, re-armed by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q       <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_start_ok) begin
      r_q       <= modulus;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_in_hs) begin
        r_in_cnt <= (r_in_cnt == c_last_idx) ? '0 : r_in_cnt + 1'b1;
      end
      if (w_out_hs) begin
        r_out_cnt <= (r_out_cnt == c_last_idx) ? '0 : r_out_cnt + 1'b1;
      end
    end
  end

  // Stage 1: raw sum and signed difference, one bit wider than the operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_dif   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_in_hs;
      if (w_in_hs) begin
        r_s1_sum <= {1'b0, u} + {1'b0, p};
        r_s1_dif <= {1'b0, u} - {1'b0, p};
      end
    end
  end

  // Stage 2: modular correction into the output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_x <= w_x_nxt;
        r_y <= w_y_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ct_butterfly_stage.sv
// ============================================================================
//  Module      : tb_ct_butterfly_stage
//  Description : Self-checking bench for ct_butterfly_stage with a queue-based
//                scoreboard and randomized operands.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ct_butterfly_stage;

  localparam int DW = 8;
  localparam int N  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start;
  logic [DW-1:0] modulus;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] u;
  logic [DW-1:0] p;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] x;
  logic [DW-1:0] y;
  logic [CW-1:0] bfly_idx;
  logic          pass_done;

  ct_butterfly_stage #(
    .DATA_WIDTH(DW),
    .BFLY_COUNT(N),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .modulus  (modulus),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .u        (u),
    .p        (p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x        (x),
    .y        (y),
    .bfly_idx (bfly_idx),
    .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int idx;
  } exp_t;

  exp_t sb[$];
  int   n_cmp      = 0;
  int   n_bad      = 0;
  int   cyc        = 0;
  int   last_final = -10;
  int   pd_count   = 0;
  int   model_q    = 1;
  int   model_idx  = 0;
  bit   or_rand    = 1'b0;
  bit   or_fixed   = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer back-pressure, updated just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = or_rand ? 1'($urandom_range(1, 0)) : or_fixed;
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks stall
  // stability and the timing of pass_done.
  logic [DW-1:0] hold_x;
  logic [DW-1:0] hold_y;
  logic [CW-1:0] hold_idx;
  bit            stalled = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      stalled    = 1'b0;
      last_final = -10;
    end else begin
      check("pass_done", pass_done, (cyc == last_final + 1));
      if (pass_done) pd_count++;
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_x", x, hold_x);
        check("hold_y", y, hold_y);
        check("hold_idx", bfly_idx, hold_idx);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got x=%0d y=%0d idx=%0d required none", x, y, bfly_idx);
        end else begin
          e = sb.pop_front();
          check("x", x, e.x);
          check("y", y, e.y);
          check("bfly_idx", bfly_idx, e.idx);
          if (e.idx == N - 1) last_final = cyc;
        end
      end
      stalled  = out_valid && !out_ready;
      hold_x   = x;
      hold_y   = y;
      hold_idx = bfly_idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_pass(input int q);
    start   = 1'b1;
    modulus = DW'(q);
    tick();
    start     = 1'b0;
    model_q   = q;
    model_idx = 0;
  endtask

  task automatic push_exp(input int uu, input int pp);
    exp_t e;
    e.x   = (uu + pp) % model_q;
    e.y   = (uu - pp + model_q) % model_q;
    e.idx = model_idx;
    sb.push_back(e);
    model_idx = (model_idx + 1) % N;
  endtask

  task automatic send(input int uu, input int pp, output int waits);
    in_valid = 1'b1;
    u        = DW'(uu);
    p        = DW'(pp);
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(uu, pp);
        tick();
        break;
      end
      tick();
      waits++;
      if (waits >= 60) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got no accept in %0d cycles required accept", waits);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input int count);
    int w;
    for (int i = 0; i < count; i++) begin
      send(int'($urandom_range(model_q - 1, 0)), int'($urandom_range(model_q - 1, 0)), w);
    end
  endtask

  task automatic wait_pass(input int target);
    int k = 0;
    while (pd_count < target && k < 300) begin
      tick();
      k++;
    end
    check("pass_complete", pd_count >= target, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_pass_done"}, pass_done, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_bfly_idx"}, bfly_idx, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    start    = 1'b0;
    in_valid = 1'b0;
    u        = '0;
    p        = '0;
    modulus  = '0;
    #2 rst = 1'b0;
    #10;
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Pass 1: q=251, single butterfly latency, then fill the pass.
    begin_pass(251);
    send(200, 100, w);
    check("lat_edge1_valid", out_valid, 0);
    tick();
    check("lat_edge2_valid", out_valid, 1);
    check("lat_x", x, 49);
    check("lat_y", y, 100);
    check("lat_idx", bfly_idx, 0);
    send_rand(15);
    wait_pass(1);

    // Pass 2: q=251 boundary operands back to back, then random fill.
    begin_pass(251);
    send(10, 20, w);
    check("b2b_wait0", w, 0);
    send(250, 250, w);
    check("b2b_wait1", w, 0);
    send(0, 0, w);
    check("b2b_wait2", w, 0);
    or_rand = 1'b1;
    send_rand(13);
    or_rand = 1'b0;
    wait_pass(2);

    // Pass 3: q=97 full stream; an extra input must never be accepted.
    begin_pass(97);
    send_rand(16);
    in_valid = 1'b1;
    u        = 8'd5;
    p        = 8'd7;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_17th_accept", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    wait_pass(3);

    // Pass 4: q=97 with a 10-cycle stall and an ignored start (q=13).
    begin_pass(97);
    or_fixed = 1'b0;
    send(int'($urandom_range(96, 0)), int'($urandom_range(96, 0)), w);
    check("stall_accept1_wait", w, 0);
    send(int'($urandom_range(96, 0)), int'($urandom_range(96, 0)), w);
    check("stall_accept2_wait", w, 0);
    in_valid = 1'b1;
    start    = 1'b1;
    modulus  = 8'd13;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      tick();
      start = 1'b0;
    end
    or_fixed = 1'b1;
    send(96, 1, w);
    or_rand = 1'b1;
    send_rand(13);
    or_rand = 1'b0;
    wait_pass(4);

    // Pass 5: reset with two butterflies in flight.
    begin_pass(17);
    or_fixed = 1'b0;
    send(int'($urandom_range(16, 1)), int'($urandom_range(16, 0)), w);
    send(int'($urandom_range(16, 0)), int'($urandom_range(16, 0)), w);
    #3 rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    or_fixed = 1'b1;
    tick();

    // Pass 6: fresh pass after reset, q=17.
    begin_pass(17);
    send(16, 5, w);
    tick();
    check("post_rst_x", x, 4);
    check("post_rst_y", y, 11);
    or_rand = 1'b1;
    send_rand(15);
    or_rand = 1'b0;
    wait_pass(5);

    repeat (4) tick();
    check("scoreboard_empty", sb.size(), 0);
    check("pass_count", pd_count, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
